// File: rtl/cp_insert_mc.sv
// -----------------------------------------------------------------------------
// cp_insert_mc
// Multi-channel cyclic-prefix inserter for the LTE IFFT output path.
// Complete input frames are buffered in a two-bank ping-pong RAM. Each bank is
// then replayed as [last cp_len samples | full symbol], one sample every
// fs_ratio clocks. In bypass mode the input stream is passed through with the
// same two-cycle latency and aligned flags.
//
// Ports
//   clk        clock
//   reset      synchronous, active-low reset
//   bypass     1 = pass-through, 0 = CP insertion
//   fft_num    frame length select, N = 2**ADDR_NBIT >> fft_num
//   cp_len     cyclic prefix length (must be < N), latched at sop
//   fs_ratio   clocks per output sample (0 behaves as 1), latched at sop
//   fst_cp     frame is first symbol of slot, latched at sop
//   din_sop    start of frame, qualified by din_valid
//   din_valid  input sample valid
//   din_data   {..., ch1{I,Q}, ch0{I,Q}}
//   dout_data  output samples, 0 when dout_v = 0
//   dout_v     output sample valid
//   dout_h     first output sample of a frame
//   dout_s     dout_h of a frame flagged fst_cp
//   overrun    one-cycle pulse: incoming frame dropped, target bank still full
//   busy       reader active or any bank holding a frame
// -----------------------------------------------------------------------------
module cp_insert_mc #(
    parameter int DATA_NBIT  = 16,
    parameter int NCH        = 2,
    parameter int ADDR_NBIT  = 11,
    parameter int RATIO_NBIT = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bypass,
    input  logic [2:0]                 fft_num,
    input  logic [ADDR_NBIT-1:0]       cp_len,
    input  logic [RATIO_NBIT-1:0]      fs_ratio,
    input  logic                       fst_cp,
    input  logic                       din_sop,
    input  logic                       din_valid,
    input  logic [NCH*2*DATA_NBIT-1:0] din_data,
    output logic [NCH*2*DATA_NBIT-1:0] dout_data,
    output logic                       dout_v,
    output logic                       dout_h,
    output logic                       dout_s,
    output logic                       overrun,
    output logic                       busy
);

    localparam int DW    = NCH * 2 * DATA_NBIT;
    localparam int NW    = ADDR_NBIT + 1;
    localparam int DEPTH = 2 ** (ADDR_NBIT + 1);

    localparam logic [ADDR_NBIT-1:0]  ONE_A = {{(ADDR_NBIT-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0]         ONE_N = {{(NW-1){1'b0}}, 1'b1};
    localparam logic [RATIO_NBIT-1:0] ONE_R = {{(RATIO_NBIT-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CP   = 2'd1,
        ST_SYM  = 2'd2
    } state_t;

    // Frame length from fft_num; NW bits so that N = 2**ADDR_NBIT fits.
    function automatic logic [NW-1:0] frame_len(input logic [2:0] sel);
        logic [NW-1:0] max_len;
        max_len = {1'b1, {ADDR_NBIT{1'b0}}};
        return max_len >> sel;
    endfunction

    // Terminal value of the pace counter; a ratio of 0 paces like 1.
    function automatic logic [RATIO_NBIT-1:0] ratio_m1(input logic [RATIO_NBIT-1:0] r);
        logic [RATIO_NBIT-1:0] res;
        if (r == {RATIO_NBIT{1'b0}}) begin
            res = {RATIO_NBIT{1'b0}};
        end else begin
            res = r - ONE_R;
        end
        return res;
    endfunction

    // Sample buffer: bank bit in the MSB of the address
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] ram_rdata_q;

    // Write side
    logic                  wbank_q, wbank_d;
    logic [ADDR_NBIT-1:0]  waddr_q, waddr_d;
    logic                  wr_act_q, wr_act_d;
    logic [1:0]            bank_full_q, bank_full_d;
    logic [1:0][NW-1:0]        cfg_n_q, cfg_n_d;
    logic [1:0][ADDR_NBIT-1:0] cfg_cp_q, cfg_cp_d;
    logic [1:0][RATIO_NBIT-1:0] cfg_ratio_q, cfg_ratio_d;
    logic [1:0]            cfg_fst_q, cfg_fst_d;

    // Read side
    state_t                state_q, state_d;
    logic                  rbank_q, rbank_d;
    logic [ADDR_NBIT-1:0]  raddr_q, raddr_d;
    logic [RATIO_NBIT-1:0] pace_q, pace_d;
    logic                  first_q, first_d;

    // Output pipeline: stage 1 aligns with the RAM read register
    logic          s1_v_q, s1_v_d;
    logic          s1_h_q, s1_h_d;
    logic          s1_s_q, s1_s_d;
    logic          s1_byp_q, s1_byp_d;
    logic [DW-1:0] byp_data_q, byp_data_d;
    logic [DW-1:0] dout_data_q, dout_data_d;
    logic          dout_v_q, dout_v_d;
    logic          dout_h_q, dout_h_d;
    logic          dout_s_q, dout_s_d;
    logic          overrun_q, overrun_d;
    logic          busy_q, busy_d;

    // Combinational helpers
    logic                  we_s;
    logic [ADDR_NBIT-1:0]  wr_addr_s;
    logic                  rd_s;
    logic                  rd_first_s;
    logic                  release_s;
    logic                  start_s;
    logic                  start_bank_s;
    logic                  other_bank_s;
    logic [NW-1:0]         cur_n_s;
    logic [RATIO_NBIT-1:0] ratio_m1_s;
    logic                  rd_last_s;
    logic                  wr_full_s;

    // Next-state logic for writer, reader and output pipeline
    always_comb begin
        wbank_d     = wbank_q;
        waddr_d     = waddr_q;
        wr_act_d    = wr_act_q;
        bank_full_d = bank_full_q;
        cfg_n_d     = cfg_n_q;
        cfg_cp_d    = cfg_cp_q;
        cfg_ratio_d = cfg_ratio_q;
        cfg_fst_d   = cfg_fst_q;
        state_d     = state_q;
        rbank_d     = rbank_q;
        raddr_d     = raddr_q;
        pace_d      = pace_q;
        first_d     = first_q;
        overrun_d   = 1'b0;
        we_s        = 1'b0;
        wr_addr_s   = {ADDR_NBIT{1'b0}};
        rd_s        = 1'b0;
        rd_first_s  = 1'b0;
        release_s   = 1'b0;
        start_s     = 1'b0;
        start_bank_s = rbank_q;
        other_bank_s = ~rbank_q;
        cur_n_s     = cfg_n_q[rbank_q];
        ratio_m1_s  = ratio_m1(cfg_ratio_q[rbank_q]);
        rd_last_s   = ({1'b0, raddr_q} == (cur_n_s - ONE_N));
        wr_full_s   = 1'b0;

        // Reader
        case (state_q)
            ST_IDLE: begin
                if (bank_full_q[rbank_q]) begin
                    start_s      = 1'b1;
                    start_bank_s = rbank_q;
                end else begin
                    start_s = 1'b0;
                end
            end
            ST_CP, ST_SYM: begin
                if (pace_q == ratio_m1_s) begin
                    rd_s       = 1'b1;
                    rd_first_s = first_q;
                    first_d    = 1'b0;
                    pace_d     = {RATIO_NBIT{1'b0}};
                    if (!rd_last_s) begin
                        raddr_d = raddr_q + ONE_A;
                    end else if (state_q == ST_CP) begin
                        state_d = ST_SYM;
                        raddr_d = {ADDR_NBIT{1'b0}};
                    end else begin
                        // End of frame: free the bank and chain straight
                        // into the other bank when it already holds a frame.
                        release_s            = 1'b1;
                        bank_full_d[rbank_q] = 1'b0;
                        rbank_d              = other_bank_s;
                        if (bank_full_q[other_bank_s]) begin
                            start_s      = 1'b1;
                            start_bank_s = other_bank_s;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    pace_d = pace_q + ONE_R;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_s) begin
            pace_d  = {RATIO_NBIT{1'b0}};
            first_d = 1'b1;
            if (cfg_cp_q[start_bank_s] != {ADDR_NBIT{1'b0}}) begin
                state_d = ST_CP;
                raddr_d = ADDR_NBIT'(cfg_n_q[start_bank_s] - {1'b0, cfg_cp_q[start_bank_s]});
            end else begin
                state_d = ST_SYM;
                raddr_d = {ADDR_NBIT{1'b0}};
            end
        end else begin
            start_bank_s = start_bank_s;
        end

        // Writer; a bank released this cycle counts as free
        wr_full_s = bank_full_q[wbank_q] && !(release_s && (rbank_q == wbank_q));
        if (bypass) begin
            // Buffer path is held idle; any partial frame is abandoned
            wr_act_d    = 1'b0;
            wbank_d     = 1'b0;
            waddr_d     = {ADDR_NBIT{1'b0}};
            bank_full_d = 2'b00;
            state_d     = ST_IDLE;
            rbank_d     = 1'b0;
            raddr_d     = {ADDR_NBIT{1'b0}};
            pace_d      = {RATIO_NBIT{1'b0}};
            first_d     = 1'b0;
        end else if (din_valid && din_sop) begin
            if (wr_full_s) begin
                overrun_d = 1'b1;
                wr_act_d  = 1'b0;
            end else begin
                we_s                 = 1'b1;
                wr_addr_s            = {ADDR_NBIT{1'b0}};
                waddr_d              = ONE_A;
                wr_act_d             = 1'b1;
                cfg_n_d[wbank_q]     = frame_len(fft_num);
                cfg_cp_d[wbank_q]    = cp_len;
                cfg_ratio_d[wbank_q] = fs_ratio;
                cfg_fst_d[wbank_q]   = fst_cp;
            end
        end else if (din_valid && wr_act_q) begin
            we_s      = 1'b1;
            wr_addr_s = waddr_q;
            if ({1'b0, waddr_q} == (cfg_n_q[wbank_q] - ONE_N)) begin
                bank_full_d[wbank_q] = 1'b1;
                wbank_d              = ~wbank_q;
                wr_act_d             = 1'b0;
            end else begin
                waddr_d = waddr_q + ONE_A;
            end
        end else begin
            we_s = 1'b0;
        end

        // Output pipeline
        s1_byp_d   = bypass;
        byp_data_d = din_data;
        if (bypass) begin
            s1_v_d = din_valid;
            s1_h_d = din_sop && din_valid;
            s1_s_d = din_sop && din_valid && fst_cp;
        end else begin
            s1_v_d = rd_s;
            s1_h_d = rd_first_s;
            s1_s_d = rd_first_s && cfg_fst_q[rbank_q];
        end
        dout_v_d = s1_v_q;
        dout_h_d = s1_h_q;
        dout_s_d = s1_s_q;
        if (!s1_v_q) begin
            dout_data_d = {DW{1'b0}};
        end else if (s1_byp_q) begin
            dout_data_d = byp_data_q;
        end else begin
            dout_data_d = ram_rdata_q;
        end
        busy_d = (state_d != ST_IDLE) || (bank_full_d != 2'b00);
    end

    // Buffer RAM: single write port, registered read port
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[{wbank_q, wr_addr_s}] <= din_data;
        end
        ram_rdata_q <= mem_q[{rbank_q, raddr_q}];
    end

    // Control, configuration and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wbank_q     <= 1'b0;
            waddr_q     <= {ADDR_NBIT{1'b0}};
            wr_act_q    <= 1'b0;
            bank_full_q <= 2'b00;
            cfg_n_q     <= '0;
            cfg_cp_q    <= '0;
            cfg_ratio_q <= '0;
            cfg_fst_q   <= 2'b00;
            state_q     <= ST_IDLE;
            rbank_q     <= 1'b0;
            raddr_q     <= {ADDR_NBIT{1'b0}};
            pace_q      <= {RATIO_NBIT{1'b0}};
            first_q     <= 1'b0;
            s1_v_q      <= 1'b0;
            s1_h_q      <= 1'b0;
            s1_s_q      <= 1'b0;
            s1_byp_q    <= 1'b0;
            byp_data_q  <= {DW{1'b0}};
            dout_data_q <= {DW{1'b0}};
            dout_v_q    <= 1'b0;
            dout_h_q    <= 1'b0;
            dout_s_q    <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            wbank_q     <= wbank_d;
            waddr_q     <= waddr_d;
            wr_act_q    <= wr_act_d;
            bank_full_q <= bank_full_d;
            cfg_n_q     <= cfg_n_d;
            cfg_cp_q    <= cfg_cp_d;
            cfg_ratio_q <= cfg_ratio_d;
            cfg_fst_q   <= cfg_fst_d;
            state_q     <= state_d;
            rbank_q     <= rbank_d;
            raddr_q     <= raddr_d;
            pace_q      <= pace_d;
            first_q     <= first_d;
            s1_v_q      <= s1_v_d;
            s1_h_q      <= s1_h_d;
            s1_s_q      <= s1_s_d;
            s1_byp_q    <= s1_byp_d;
            byp_data_q  <= byp_data_d;
            dout_data_q <= dout_data_d;
            dout_v_q    <= dout_v_d;
            dout_h_q    <= dout_h_d;
            dout_s_q    <= dout_s_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign dout_data = dout_data_q;
    assign dout_v    = dout_v_q;
    assign dout_h    = dout_h_q;
    assign dout_s    = dout_s_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cp_insert_mc.sv
// -----------------------------------------------------------------------------
// tb_cp_insert_mc
// Directed bench for cp_insert_mc. Expected output frames are built from the
// CP rule (tail of the symbol, then the whole symbol) into a queue; a monitor
// checks every cycle's outputs against it, including sample spacing. Literal
// expectations pin the model on the key scenarios.
// -----------------------------------------------------------------------------
module tb_cp_insert_mc;

    localparam int DW  = 64;
    localparam int CAP = 4096;

    typedef struct {
        logic [DW-1:0] d;
        logic          h;
        logic          s;
        int            gap;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          bypass;
    logic [2:0]    fft_num;
    logic [10:0]   cp_len;
    logic [6:0]    fs_ratio;
    logic          fst_cp;
    logic          din_sop;
    logic          din_valid;
    logic [DW-1:0] din_data;
    logic [DW-1:0] dout_data;
    logic          dout_v;
    logic          dout_h;
    logic          dout_s;
    logic          overrun;
    logic          busy;

    int checks;
    int failures;
    int cyc;
    int last_v;
    int last_h_cyc;
    int sop_cyc;
    int ovr_cnt;
    int h_cnt;
    int cap_n;
    logic [DW-1:0] cap_d [CAP];
    logic          cap_s [CAP];
    exp_t exp_q [$];

    cp_insert_mc dut (
        .clk       (clk),
        .reset     (reset),
        .bypass    (bypass),
        .fft_num   (fft_num),
        .cp_len    (cp_len),
        .fs_ratio  (fs_ratio),
        .fst_cp    (fst_cp),
        .din_sop   (din_sop),
        .din_valid (din_valid),
        .din_data  (din_data),
        .dout_data (dout_data),
        .dout_v    (dout_v),
        .dout_h    (dout_h),
        .dout_s    (dout_s),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sample idx of a frame tagged 'tag': ch0 I = idx, ch0 Q = tag
    function automatic logic [DW-1:0] smp(input int tag, input int idx);
        logic [15:0] i0, q0, i1, q1;
        i0 = 16'(idx);
        q0 = 16'(tag);
        i1 = ~16'(idx);
        q1 = 16'(tag + 256);
        return {i1, q1, i0, q0};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output frame of length n+cp: samples n-cp..n-1, then 0..n-1
    task automatic expect_frame(input int n, input int cp, input int tag, input logic fst,
                                input int gap, input int first_gap);
        exp_t e;
        int idx;
        for (int k = 0; k < n + cp; k++) begin
            idx   = (k < cp) ? (n - cp + k) : (k - cp);
            e.d   = smp(tag, idx);
            e.h   = (k == 0);
            e.s   = (k == 0) && fst;
            e.gap = (k == 0) ? first_gap : gap;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input int n_samp, input int tag, input logic [2:0] fn, input int cp,
                              input int ratio, input logic fst, input logic exp_ovr);
        fft_num  = fn;
        cp_len   = 11'(cp);
        fs_ratio = 7'(ratio);
        fst_cp   = fst;
        for (int i = 0; i < n_samp; i++) begin
            din_sop   = (i == 0);
            din_valid = 1'b1;
            din_data  = smp(tag, i);
            if (i == 0) sop_cyc = cyc;
            @(posedge clk);
            #1;
            if (i == 0) check("overrun_after_sop", overrun, exp_ovr);
        end
        din_sop   = 1'b0;
        din_valid = 1'b0;
        din_data  = '0;
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            tick(1);
            k++;
        end
        check(name, exp_q.size(), 0);
        tick(20);
    endtask

    // Per-cycle output checker
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (overrun === 1'b1) ovr_cnt++;
            if (dout_h === 1'b1) begin
                h_cnt++;
                last_h_cyc = cyc;
            end
            if (dout_v === 1'b1) begin
                if (cap_n < CAP) begin
                    cap_d[cap_n] = dout_data;
                    cap_s[cap_n] = dout_s;
                end
                cap_n++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_sample actual=%h expected=none", dout_data);
                end else begin
                    e = exp_q.pop_front();
                    if (dout_data !== e.d || dout_h !== e.h || dout_s !== e.s) begin
                        failures++;
                        $display("FAIL out_sample actual=%h h=%b s=%b expected=%h h=%b s=%b",
                                 dout_data, dout_h, dout_s, e.d, e.h, e.s);
                    end
                    if (e.gap != 0) begin
                        checks++;
                        if (cyc - last_v != e.gap) begin
                            failures++;
                            $display("FAIL out_spacing actual=%0d expected=%0d", cyc - last_v, e.gap);
                        end
                    end
                end
                last_v = cyc;
            end else begin
                checks++;
                if (dout_data !== '0 || dout_h !== 1'b0 || dout_s !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_out actual=%h h=%b s=%b expected=0", dout_data, dout_h, dout_s);
                end
            end
        end
    endtask

    initial begin
        int base;
        int ob;
        int hb;
        checks = 0; failures = 0; last_v = 0; last_h_cyc = 0; sop_cyc = 0;
        ovr_cnt = 0; h_cnt = 0; cap_n = 0;
        reset = 1'b0; bypass = 1'b0; fft_num = 3'd0; cp_len = 11'd0; fs_ratio = 7'd1;
        fst_cp = 1'b0; din_sop = 1'b0; din_valid = 1'b0; din_data = '0;
        tick(3);

        // Reset state
        check("reset_dout_v", dout_v, 0);
        check("reset_dout_data", dout_data, 0);
        check("reset_dout_h", dout_h, 0);
        check("reset_overrun", overrun, 0);
        check("reset_busy", busy, 0);
        reset = 1'b1;
        fork
            monitor();
        join_none
        tick(5);

        // N=128, cp=9, ratio 1
        base = cap_n; hb = h_cnt;
        expect_frame(128, 9, 1, 1'b0, 1, 0);
        send_frame(128, 1, 3'd4, 9, 1, 1'b0, 1'b0);
        wait_drain(1000, "drain_cp9");
        check("cp9_count", cap_n - base, 137);
        check("cp9_first_i", cap_d[base][31:16], 119);
        check("cp9_last_cp_i", cap_d[base + 8][31:16], 127);
        check("cp9_sym0_i", cap_d[base + 9][31:16], 0);
        check("cp9_end_i", cap_d[base + 136][31:16], 127);
        check("cp9_h_count", h_cnt - hb, 1);

        // N=256, cp=32, ratio 4
        base = cap_n;
        expect_frame(256, 32, 2, 1'b0, 4, 0);
        send_frame(256, 2, 3'd3, 32, 4, 1'b0, 1'b0);
        check("busy_while_full", busy, 1);
        wait_drain(3000, "drain_r4");
        check("r4_count", cap_n - base, 288);
        check("busy_after_r4", busy, 0);

        // cp=0, fst_cp=1, ratio 2
        base = cap_n;
        expect_frame(128, 0, 3, 1'b1, 2, 0);
        send_frame(128, 3, 3'd4, 0, 2, 1'b1, 1'b0);
        wait_drain(1000, "drain_cp0");
        check("cp0_count", cap_n - base, 128);
        check("cp0_first_i", cap_d[base][31:16], 0);
        check("cp0_first_s", cap_s[base], 1);

        // Three back-to-back frames at ratio 8; third dropped
        base = cap_n; ob = ovr_cnt;
        expect_frame(128, 9, 4, 1'b0, 8, 0);
        expect_frame(128, 9, 5, 1'b0, 8, 8);
        send_frame(128, 4, 3'd4, 9, 8, 1'b0, 1'b0);
        send_frame(128, 5, 3'd4, 9, 8, 1'b0, 1'b0);
        send_frame(128, 6, 3'd4, 9, 8, 1'b0, 1'b1);
        wait_drain(4000, "drain_ovr");
        check("ovr_count", ovr_cnt - ob, 1);
        check("ovr_out_count", cap_n - base, 274);
        check("ovr_2nd_tag", cap_d[base + 137][15:0], 5);

        // Restart after 50 samples
        base = cap_n;
        expect_frame(128, 9, 8, 1'b0, 1, 0);
        send_frame(50, 7, 3'd4, 9, 1, 1'b0, 1'b0);
        send_frame(128, 8, 3'd4, 9, 1, 1'b0, 1'b0);
        wait_drain(1000, "drain_restart");
        check("restart_count", cap_n - base, 137);
        check("restart_tag", cap_d[base][15:0], 8);

        // Bypass
        bypass = 1'b1;
        tick(3);
        base = cap_n;
        for (int i = 0; i < 20; i++) begin
            exp_t e;
            e.d = smp(10, i); e.h = (i == 0); e.s = (i == 0); e.gap = (i == 0) ? 0 : 1;
            exp_q.push_back(e);
        end
        send_frame(20, 10, 3'd4, 9, 1, 1'b1, 1'b0);
        wait_drain(100, "drain_bypass");
        check("bypass_latency", last_h_cyc - sop_cyc, 2);
        check("bypass_count", cap_n - base, 20);
        check("bypass_busy", busy, 0);
        bypass = 1'b0;
        tick(3);

        // Reset during readout, then normal recovery
        expect_frame(256, 32, 11, 1'b0, 4, 0);
        send_frame(256, 11, 3'd3, 32, 4, 1'b0, 1'b0);
        tick(300);
        reset = 1'b0;
        tick(1);
        exp_q.delete();
        check("midreset_dout_v", dout_v, 0);
        check("midreset_dout_data", dout_data, 0);
        check("midreset_busy", busy, 0);
        tick(3);
        reset = 1'b1;
        tick(50);
        base = cap_n;
        expect_frame(128, 9, 12, 1'b0, 1, 0);
        send_frame(128, 12, 3'd4, 9, 1, 1'b0, 1'b0);
        wait_drain(1000, "drain_recover");
        check("recover_count", cap_n - base, 137);
        check("recover_first_i", cap_d[base][31:16], 119);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
